// File: rtl/event_pending_latch_pkg.sv
// Shared types and helpers for the event pending latch and related arbiters.
package event_pending_latch_pkg;

  typedef enum logic {
    StIdle,
    StOffer
  } epl_state_t;

  localparam int unsigned MaxWidth = 64;

  // Highest set bit as one-hot; zero in gives zero out.
  function automatic logic [MaxWidth-1:0] msb_onehot(input logic [MaxWidth-1:0] vec);
    logic [MaxWidth-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (vec[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/event_pending_latch_picker.sv
// Combinational highest-index-wins one-hot picker, shared with other arbiters.
module msb_onehot_picker #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_pending_latch.sv
// Sticky per-line pending capture with masked, highest-index-first one-hot grant offers.
module event_pending_latch
  import event_pending_latch_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] evt_in,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             clr_all,
  output logic [WIDTH-1:0] pending_o,
  output logic [WIDTH-1:0] overflow_o,
  output logic             grant_valid,
  output logic [WIDTH-1:0] grant_onehot,
  input  logic             grant_ready
);

  epl_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic [WIDTH-1:0] evt_q;
  logic             grant_valid_q, grant_valid_d;
  logic [WIDTH-1:0] grant_onehot_q, grant_onehot_d;

  logic             handshake;
  logic [WIDTH-1:0] set_vec, clr_vec, pick;

  msb_onehot_picker #(
    .WIDTH(WIDTH)
  ) u_picker (
    .vec_i   (pending_q & mask_in),
    .onehot_o(pick)
  );

  assign handshake = grant_valid_q & grant_ready;
  assign clr_vec   = handshake ? grant_onehot_q : '0;
  assign set_vec   = EDGE_DETECT ? (evt_in & ~evt_q) : evt_in;

  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_onehot_d = grant_onehot_q;
    // A set on the line being cleared by the handshake keeps it pending, no overflow.
    pending_d      = (pending_q & ~clr_vec) | set_vec;
    overflow_d     = overflow_q | (set_vec & pending_q & ~clr_vec);

    unique case (state_q)
      StIdle: begin
        if (pick != '0) begin
          state_d        = StOffer;
          grant_valid_d  = 1'b1;
          grant_onehot_d = pick;
        end
      end
      StOffer: begin
        if (handshake) begin
          state_d        = StIdle;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over same-cycle events and withdraws any open offer.
    if (clr_all) begin
      state_d        = StIdle;
      grant_valid_d  = 1'b0;
      grant_onehot_d = '0;
      pending_d      = '0;
      overflow_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      overflow_q     <= '0;
      evt_q          <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      overflow_q     <= overflow_d;
      evt_q          <= evt_in;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end

  assign pending_o    = pending_q;
  assign overflow_o   = overflow_q;
  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_event_pending_latch.sv
// Directed self-checking bench for event_pending_latch (WIDTH=8, EDGE_DETECT=1).
module tb_event_pending_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] evt_in, mask_in;
  logic       clr_all, grant_ready;
  logic [7:0] pending_o, overflow_o, grant_onehot;
  logic       grant_valid;

  int n_checks = 0;
  int n_fail   = 0;

  event_pending_latch #(
    .WIDTH      (8),
    .EDGE_DETECT(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .evt_in      (evt_in),
    .mask_in     (mask_in),
    .clr_all     (clr_all),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o),
    .grant_valid (grant_valid),
    .grant_onehot(grant_onehot),
    .grant_ready (grant_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] evt;
    logic       rdy;
    logic [7:0] exp_pend;
    logic       exp_valid;
    logic [7:0] exp_oh;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] pend, input logic [7:0] ovf,
                           input logic valid, input logic [7:0] oh);
    check({name, ".pending"}, pending_o, pend);
    check({name, ".overflow"}, overflow_o, ovf);
    check({name, ".valid"}, {7'd0, grant_valid}, {7'd0, valid});
    check({name, ".onehot"}, grant_onehot, oh);
  endtask

  // Apply inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic [7:0] evt, input logic rdy);
    evt_in      = evt;
    grant_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    rst         = 1'b1;
    evt_in      = '0;
    mask_in     = 8'hFF;
    clr_all     = 1'b0;
    grant_ready = 1'b0;
    #1;
    check_all("reset", 8'h00, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic capture/grant, then priority order with ready held high.
    vecs[0]  = '{8'h08, 1'b0, 8'h08, 1'b0, 8'h00};
    vecs[1]  = '{8'h00, 1'b1, 8'h08, 1'b1, 8'h08};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{8'h91, 1'b1, 8'h91, 1'b0, 8'h00};
    vecs[5]  = '{8'h00, 1'b1, 8'h91, 1'b1, 8'h80};
    vecs[6]  = '{8'h00, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[7]  = '{8'h00, 1'b1, 8'h11, 1'b1, 8'h10};
    vecs[8]  = '{8'h00, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[9]  = '{8'h00, 1'b1, 8'h01, 1'b1, 8'h01};
    vecs[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].evt, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pend, 8'h00, vecs[i].exp_valid,
                vecs[i].exp_oh);
    end

    // Stall: offer of line 2 held while line 7 arrives and the mask drops.
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    check_all("stall.offer", 8'h04, 8'h00, 1'b1, 8'h04);
    mask_in = 8'h00;
    step(8'h80, 1'b0);
    check_all("stall.c0", 8'h84, 8'h00, 1'b1, 8'h04);
    for (int i = 1; i < 5; i++) begin
      step(8'h00, 1'b0);
      check_all($sformatf("stall.c%0d", i), 8'h84, 8'h00, 1'b1, 8'h04);
    end
    step(8'h00, 1'b1);
    check_all("stall.hs", 8'h80, 8'h00, 1'b0, 8'h00);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check_all("mask.hold", 8'h80, 8'h00, 1'b0, 8'h00);
    mask_in = 8'h80;
    step(8'h00, 1'b0);
    check_all("mask.offer", 8'h80, 8'h00, 1'b1, 8'h80);
    step(8'h00, 1'b1);
    check_all("mask.hs", 8'h00, 8'h00, 1'b0, 8'h00);
    mask_in = 8'hFF;

    // Set and handshake-clear on the same line: set wins, no overflow.
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    step(8'h04, 1'b1);
    check_all("coll.hs", 8'h04, 8'h00, 1'b0, 8'h00);
    step(8'h00, 1'b0);
    check_all("coll.reoffer", 8'h04, 8'h00, 1'b1, 8'h04);
    step(8'h04, 1'b0);
    check_all("ovf.set", 8'h04, 8'h04, 1'b1, 8'h04);
    step(8'h00, 1'b1);
    check_all("ovf.sticky", 8'h00, 8'h04, 1'b0, 8'h00);

    // clr_all during an offer with line 5 rising the same cycle.
    step(8'h02, 1'b0);
    step(8'h00, 1'b0);
    check_all("clr.offer", 8'h02, 8'h04, 1'b1, 8'h02);
    clr_all = 1'b1;
    step(8'h20, 1'b0);
    clr_all = 1'b0;
    check_all("clr.edge", 8'h00, 8'h00, 1'b0, 8'h00);
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    check_all("clr.after", 8'h00, 8'h00, 1'b0, 8'h00);

    // Async reset mid-offer with pending A5.
    step(8'hA5, 1'b0);
    step(8'h00, 1'b0);
    check_all("rst.offer", 8'hA5, 8'h00, 1'b1, 8'h80);
    #2 rst = 1'b1;
    #1;
    check_all("rst.async", 8'h00, 8'h00, 1'b0, 8'h00);
    #1 rst = 1'b0;
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check_all("rst.idle", 8'h00, 8'h00, 1'b0, 8'h00);
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);
    check_all("rst.new", 8'h01, 8'h00, 1'b1, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
